// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port registered memory.
// Requests are accepted in IDLE only; each transfer runs IDLE -> ACCESS -> RESP.
module mem_arbiter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned ADDRSIZE    = 12,
    parameter int unsigned INIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_valid,
    input  logic [ADDRSIZE-1:0] i_addr,
    output logic                i_ready,
    output logic                i_rvalid,
    output logic [WIDTH-1:0]    i_rdata,
    input  logic                d_valid,
    input  logic                d_wr,
    input  logic [ADDRSIZE-1:0] d_addr,
    input  logic [WIDTH-1:0]    d_wdata,
    output logic                d_ready,
    output logic                d_rvalid,
    output logic [WIDTH-1:0]    d_rdata,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_din,
    output logic                mem_wr,
    output logic                mem_reset,
    input  logic [WIDTH-1:0]    mem_dout,
    output logic                busy
);

    localparam int unsigned     CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CYCLES - 1);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]          state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                last_gnt_q,  last_gnt_d;   // 1 = port 1 won last
    logic                gnt_q,       gnt_d;        // 1 = port 1 owns current transfer
    logic                wr_q,        wr_d;
    logic [ADDRSIZE-1:0] mem_addr_q,  mem_addr_d;
    logic [WIDTH-1:0]    mem_din_q,   mem_din_d;
    logic                mem_wr_q,    mem_wr_d;
    logic                mem_reset_q, mem_reset_d;
    logic                i_rvalid_q,  i_rvalid_d;
    logic                d_rvalid_q,  d_rvalid_d;
    logic [WIDTH-1:0]    i_rdata_q,   i_rdata_d;
    logic [WIDTH-1:0]    d_rdata_q,   d_rdata_d;
    logic                busy_q,      busy_d;

    logic grant_i_c;
    logic grant_d_c;
    logic idle_c;

    // Alternate on contention: the port that did not win last time goes first.
    assign grant_i_c = i_valid && (!d_valid || last_gnt_q);
    assign grant_d_c = d_valid && (!i_valid || !last_gnt_q);
    assign idle_c    = (state_q == ST_IDLE);

    assign i_ready   = idle_c && grant_i_c;
    assign d_ready   = idle_c && grant_d_c;

    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_wr    = mem_wr_q;
    assign mem_reset = mem_reset_q;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = busy_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_gnt_d  = last_gnt_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_wr_d    = mem_wr_q;
        mem_reset_d = 1'b0;
        i_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            ST_INIT: begin
                mem_wr_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_reset_d = 1'b1;
                    cnt_d       = cnt_q - CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (i_ready || d_ready) begin
                    state_d    = ST_ACCESS;
                    gnt_d      = d_ready;
                    last_gnt_d = d_ready;
                    wr_d       = d_ready && d_wr;
                    mem_wr_d   = d_ready && d_wr;
                    mem_addr_d = d_ready ? d_addr : i_addr;
                    if (d_ready) begin
                        mem_din_d = d_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                mem_wr_d = 1'b0;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (!gnt_q) begin
                    i_rvalid_d = 1'b1;
                    i_rdata_d  = mem_dout;
                end else begin
                    d_rvalid_d = 1'b1;
                    if (!wr_q) begin
                        d_rdata_d = mem_dout;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= CNT_INIT;
            last_gnt_q  <= 1'b1;
            gnt_q       <= 1'b0;
            wr_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_wr_q    <= 1'b0;
            mem_reset_q <= 1'b1;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_gnt_q  <= last_gnt_d;
            gnt_q       <= gnt_d;
            wr_q        <= wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_wr_q    <= mem_wr_d;
            mem_reset_q <= mem_reset_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

endmodule
